// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with divide-by-zero, signed-overflow and reserved-op results resolved at accept time.
module mul_div_unit #(
    parameter int XLEN  = 64,
    parameter int ITERS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] c
);

    localparam logic [3:0] OP_MUL   = 4'd0;
    localparam logic [3:0] OP_MULW  = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_REM   = 4'd4;
    localparam logic [3:0] OP_REMU  = 4'd5;
    localparam logic [3:0] OP_DIVW  = 4'd6;
    localparam logic [3:0] OP_DIVUW = 4'd7;
    localparam logic [3:0] OP_REMW  = 4'd8;
    localparam logic [3:0] OP_REMUW = 4'd9;

    localparam int CW = $clog2(ITERS) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
        return w ? sext32(v[31:0]) : v;
    endfunction

    localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] W_MIN = {{(XLEN-31){1'b1}}, 31'b0};

    state_t state, state_n;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] x, y, acc;
    logic            mul_r, w_r, rem_r, sign_q, sign_r;

    // request decode and operand preparation
    logic            is_mul, is_w, is_wu, is_sdiv, is_rem, is_rsvd;
    logic [XLEN-1:0] pa, pb, ma, mb, fast_res;
    logic            sa, sb, div_zero, div_ovf, fast;

    always_comb begin
        is_mul  = (op == OP_MUL) || (op == OP_MULW);
        is_w    = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        is_wu   = op inside {OP_DIVUW, OP_REMUW};
        is_sdiv = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        is_rem  = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
        is_rsvd = op > OP_REMUW;

        pa = a;
        pb = b;
        if (is_w) begin
            pa = is_wu ? zext32(a[31:0]) : sext32(a[31:0]);
            pb = is_wu ? zext32(b[31:0]) : sext32(b[31:0]);
        end

        sa = is_sdiv & pa[XLEN-1];
        sb = is_sdiv & pb[XLEN-1];
        ma = sa ? -pa : pa;
        mb = sb ? -pb : pb;

        div_zero = !is_mul && !is_rsvd && (pb == '0);
        div_ovf  = is_sdiv && (pb == '1) && (pa == (is_w ? W_MIN : X_MIN));
        fast     = is_rsvd | div_zero | div_ovf;

        fast_res = '0;
        if (div_zero)
            fast_res = is_rem ? pa : '1;
        else if (div_ovf)
            fast_res = is_rem ? '0 : pa;
        fast_res = wfix(is_w, fast_res);
    end

    // one iteration step; for divide x holds the divisor and y shifts dividend out / quotient in
    logic [XLEN-1:0] x_n, y_n, acc_n, q_fin, r_fin, res;
    logic [XLEN:0]   rem_sh, diff;
    logic            last;

    always_comb begin
        rem_sh = {acc, y[XLEN-1]};
        diff   = rem_sh - {1'b0, x};
        if (mul_r) begin
            acc_n = acc + (y[0] ? x : '0);
            x_n   = x << 1;
            y_n   = y >> 1;
        end else begin
            acc_n = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            x_n   = x;
            y_n   = {y[XLEN-2:0], ~diff[XLEN]};
        end
        q_fin = sign_q ? -y_n : y_n;
        r_fin = sign_r ? -acc_n : acc_n;
        res   = wfix(w_r, mul_r ? acc_n : (rem_r ? r_fin : q_fin));
        last  = (cnt == CW'(ITERS - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = fast ? DONE : BUSY;
            BUSY: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            c         <= '0;
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            acc       <= '0;
            mul_r     <= 1'b0;
            w_r       <= 1'b0;
            rem_r     <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            out_valid <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        mul_r  <= is_mul;
                        w_r    <= is_w;
                        rem_r  <= is_rem;
                        sign_q <= sa ^ sb;
                        sign_r <= sa;
                        acc    <= '0;
                        cnt    <= '0;
                        x      <= is_mul ? pa : mb;
                        y      <= is_mul ? pb : ma;
                        if (fast)
                            c <= fast_res;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        x   <= x_n;
                        y   <= y_n;
                        acc <= acc_n;
                        cnt <= cnt + CW'(1);
                        if (last)
                            c <= res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed checks of mul_div_unit against an arithmetic reference model,
// including latency, backpressure, flush and asynchronous reset behaviour.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [63:0] a, b, c;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    mul_div_unit #(.XLEN(64), .ITERS(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .c(c)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // reference results from plain arithmetic on the architectural definitions
    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        longint      sx, sy;
        int          wx, wy;
        logic [31:0] ux, uy, t;
        logic [63:0] r, p;
        sx = x; sy = y; ux = x[31:0]; uy = y[31:0]; wx = ux; wy = uy;
        r = '0;
        case (o)
            4'd0: r = x * y;
            4'd1: begin p = x * y; r = sx32(p[31:0]); end
            4'd2: if (y == 0) r = '1;
                  else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
                  else r = 64'(sx / sy);
            4'd3: r = (y == 0) ? '1 : x / y;
            4'd4: if (y == 0) r = x;
                  else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0;
                  else r = 64'(sx % sy);
            4'd5: r = (y == 0) ? x : x % y;
            4'd6: if (uy == 0) r = '1;
                  else if (ux == 32'h8000_0000 && uy == '1) r = sx32(ux);
                  else begin t = 32'(wx / wy); r = sx32(t); end
            4'd7: r = (uy == 0) ? '1 : sx32(ux / uy);
            4'd8: if (uy == 0) r = sx32(ux);
                  else if (ux == 32'h8000_0000 && uy == '1) r = '0;
                  else begin t = 32'(wx % wy); r = sx32(t); end
            4'd9: r = (uy == 0) ? sx32(ux) : sx32(ux % uy);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic zero, ovf;
        if (o > 4'd9) return 1;
        if (o < 4'd2) return 65;
        if (o >= 4'd6) begin
            zero = (y[31:0] == 0);
            ovf  = (o == 4'd6 || o == 4'd8) && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF;
        end else begin
            zero = (y == 0);
            ovf  = (o == 4'd2 || o == 4'd4) && x == 64'h8000_0000_0000_0000 && y == '1;
        end
        return (zero || ovf) ? 1 : 65;
    endfunction

    function automatic logic [63:0] pick(input int mode);
        logic [63:0] r;
        case (mode)
            1: r = 64'($urandom_range(0, 20));
            2: r = '0;
            3: r = '1;
            4: r = {$urandom, 32'h8000_0000};
            5: r = 64'h8000_0000_0000_0000;
            6: r = -64'($urandom_range(1, 20));
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // responses are compared on every cycle out_valid is high, so stalls also check stability
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out_valid: got c=%h want no response", c);
            end else begin
                check("c", c, exp_q[0]);
                check("in_ready_while_valid", 64'(in_ready), 64'd0);
                if (out_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    // called #1 after a rising edge with the unit idle
    task automatic run_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] e, input int hold, input bit pin);
        int cyc;
        if (pin)
            check("model_pin", model(o, x, y), e);
        check("in_ready_before", 64'(in_ready), 64'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(e);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(latency(o, x, y)));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after", 64'(in_ready), 64'd1);
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [3:0]  o;
        logic [63:0] x, y;
        int          seen;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c", c, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b1);
        run_op(4'd1, 64'h10000, 64'h10000, 64'd0, 0, 1'b1);
        run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b1);
        run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
        run_op(4'd9, 64'hFFFF_FFFF, 64'd10, 64'd5, 0, 1'b1);
        run_op(4'd3, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
        run_op(4'd4, 64'd5, 64'd0, 64'd5, 0, 1'b1);
        run_op(4'd2, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 1'b1);
        run_op(4'd6, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0, 1'b1);
        run_op(4'd8, 64'h8000_0000, '1, 64'd0, 0, 1'b1);
        run_op(4'd12, 64'd7, 64'd9, 64'd0, 0, 1'b1);
        run_op(4'd7, 64'h1234_0000_0000_0064, 64'd7, 64'd14, 0, 1'b1);
        run_op(4'd5, 64'd100, 64'd7, 64'd2, 10, 1'b1);

        // flush in the middle of a divide: result must never appear
        op = 4'd2; a = 64'd1000; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (29) begin
            @(posedge clk); #1;
        end
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        run_op(4'd2, 64'd1000, 64'd7, 64'd142, 0, 1'b1);

        // flush while idle blocks a coincident request
        op = 4'd3; a = 64'd5; b = 64'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("idle_flush_in_ready", 64'(in_ready), 64'd1);
        check("idle_flush_out_valid", 64'(out_valid), 64'd0);

        // asynchronous reset in the middle of a multiply
        op = 4'd0; a = 64'd11; b = 64'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_c", c, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(4'd0, 64'd11, 64'd13, 64'd143, 0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = pick(int'($urandom_range(0, 6)));
            y = pick(int'($urandom_range(0, 6)));
            run_op(o, x, y, model(o, x, y), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
